lvds_fpdlink_tx: RTL and testbench
==================================

Name: lvds_fpdlink_tx

Overview:
- Parametrised FPD-Link (7:1) LVDS panel transmitter; the next generation of the single-mode 24-bit LVDS output block.
- Contains a programmable video timing generator, a pixel request handshake toward the frame buffer, VESA/JEIDA bit mapping, 18-bit (3 lane) or 24-bit (4 lane) operation, and a frame-aligned enable.
- Runs on the 7x bit clock.
- Outputs are registered single-ended serial bits; the OBUFDS instances at top level convert them to differential pairs.

Parameters:
- LANES, 4, 3 = 18-bit panel (lanes 0-2), 4 = 24-bit panel.
- MAP_JEIDA, 0, bit mapping for LANES=4: 0 = VESA, 1 = JEIDA. Ignored when LANES=3.
- H_ACTIVE, 1280, active pixels per line.
- H_FRONT, 48, horizontal front porch, in pixels.
- H_SYNC, 32, hsync width, in pixels.
- H_BACK, 80, horizontal back porch, in pixels.
- V_ACTIVE, 800, active lines.
- V_FRONT, 3, vertical front porch, in lines.
- V_SYNC, 6, vsync width, in lines.
- V_BACK, 14, vertical back porch, in lines.
- HS_POL, 0, asserted level of HS.
- VS_POL, 0, asserted level of VS.
- HW, 12, horizontal counter width.
- VW, 11, vertical counter width.

Ports:
- clk_in  in  1  bit clock, 7x pixel rate.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  transmit enable; sampled at frame boundary only.
- red  in  8  pixel red; must be valid on the cycle pix_req=1.
- green  in  8  pixel green; same timing as red.
- blue  in  8  pixel blue; same timing as red.
- pix_req  out  1  one-cycle pulse; RGB is captured on this cycle.
- pix_x  out  HW  column of the requested pixel; valid with pix_req.
- pix_y  out  VW  row of the requested pixel; valid with pix_req.
- frame_start  out  1  one-cycle pulse with pix_req for pixel (0,0).
- tx_active  out  1  current frame is enabled.
- ck1_out  out  1  LVDS clock lane serial bit.
- rxin_out  out  4  data lane serial bits; lane 3 is held 0 when LANES=3.

Behaviour:
- Reset: all outputs 0; slot counter, h counter and v counter = 0; en latch = 0.
- Symbol = 7 cycles; slot 0..6; slot 0 is transmitted first.
- Clock lane sends 1,1,0,0,0,1,1 in slot order, continuously, including when disabled.
- Counters:
  - h wraps at H_TOTAL-1 (H_TOTAL = sum of the H params) and advances at slot 6.
  - v advances when h wraps and itself wraps at V_TOTAL-1 (V_TOTAL = sum of the V params).
  - Horizontal order: active, front, sync, back. Vertical order is the same.
- Symbol load: at slot 6, shift registers load the symbol for the next (h,v); it is transmitted in slots 0..6 of the following symbol. Lane output latency = 1 cycle from load.
- First symbol after reset release: blank (DE=0, syncs inactive, colours 0). Pixel (0,0) is requested at slot 6 of this first symbol.
- DE = 1 only when h<H_ACTIVE, v<V_ACTIVE and the frame is enabled.
- HS asserted for H_SYNC pixels on every line, enabled frames only. VS asserted for V_SYNC whole lines, enabled frames only.
- Inactive sync lines are driven to the inverse of HS_POL/VS_POL.
- pix_req rules:
  - Asserted at slot 6 exactly when the symbol being loaded has DE=1.
  - Exactly H_ACTIVE*V_ACTIVE pulses per enabled frame, 7 cycles apart within a line.
  - Never asserted in a disabled frame.
- Blanking symbols carry colour bits 0.
- en sampling: en is latched at slot 6 when loading (0,0). A mid-frame change has no effect until the next frame. tx_active = latched value.
- frame_start pulses only when the latched en = 1.
- VESA mapping, slots 0..6:
  - L0 = G0,R5,R4,R3,R2,R1,R0
  - L1 = B1,B0,G5,G4,G3,G2,G1
  - L2 = DE,VS,HS,B5,B4,B3,B2
  - L3 = 0,B7,B6,G7,G6,R7,R6
- JEIDA mapping, slots 0..6:
  - L0 = G2,R7..R2
  - L1 = B3,B2,G7..G3
  - L2 = DE,VS,HS,B7..B4
  - L3 = 0,B1,B0,G1,G0,R1,R0
- LANES=3: lanes 0-2 use the JEIDA layout (6 MSBs); LSB inputs are ignored.
- rst mid-symbol: next cycle restarts from the reset state; no partial symbol is completed.

Test Plan:
- Small timing (H 4/1/1/2, V 2/1/1/1), en=1 held: 8 pix_req pulses per 280-cycle frame; pix_x sequence 0,1,2,3 on rows 0,1; frame_start once per frame, 280 cycles apart.
- Same config, HS_POL=0: rxin_out[2] slot 2 is 0 only during symbol h=5. VS is low for all symbols of v=3. DE=1 only in active symbols.
- VESA, RGB=0xA5/0x3C/0x81: deserialise lanes and compare bit-exact with the mapping table. Repeat with MAP_JEIDA=1, then LANES=3 (lane 3 stays 0).
- ck1_out: over 70 consecutive cycles it equals the repeating 1100011 pattern with no phase slip across line and frame wraps.
- en deasserted mid-frame: the current frame completes normally. The next frame has no pix_req, tx_active=0, DE/HS/VS inactive, and the clock lane keeps running. Re-assert en: transmission resumes at the following frame_start.
- Assert rst at slot 3 of an active pixel: all outputs 0 next cycle. After release, one blank symbol, then pix_req for (0,0) at cycle 7.

Source files
------------

// File: rtl/lvds_fpdlink_tx.sv
// FPD-Link 7:1 LVDS panel transmitter: video timing generator, pixel request handshake and
// VESA/JEIDA serialisation, clocked at the 7x bit rate.
module lvds_fpdlink_tx #(
  parameter int unsigned LANES     = 4,
  parameter bit          MAP_JEIDA = 1'b0,
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned H_FRONT   = 48,
  parameter int unsigned H_SYNC    = 32,
  parameter int unsigned H_BACK    = 80,
  parameter int unsigned V_ACTIVE  = 800,
  parameter int unsigned V_FRONT   = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BACK    = 14,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned HW        = 12,
  parameter int unsigned VW        = 11
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    red,
  input  logic [7:0]    green,
  input  logic [7:0]    blue,
  output logic          pix_req,
  output logic [HW-1:0] pix_x,
  output logic [VW-1:0] pix_y,
  output logic          frame_start,
  output logic          tx_active,
  output logic          ck1_out,
  output logic [3:0]    rxin_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HW-1:0] HActive = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HsStart = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HsEnd   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] HLast   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VActive = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VsStart = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VsEnd   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] VLast   = VW'(V_TOTAL - 1);

  // Bit index = slot number; slot 0 goes out first.
  localparam logic [6:0] CkPattern = 7'b1100011;
  localparam logic [3:0][6:0] BlankSym = {7'b0, {4'b0, !HS_POL, !VS_POL, 1'b0}, 7'b0, 7'b0};
  localparam bit UseJeida = MAP_JEIDA || (LANES == 3);

  logic [2:0]       slot_q;
  logic [HW-1:0]    h_q;
  logic [VW-1:0]    v_q;
  logic             en_q;
  logic [3:0][6:0]  sh_q;
  logic             ck_q;
  logic [3:0]       rx_q;

  logic             load, at_origin, frame_en, de, hs_on, vs_on, hs_bit, vs_bit;
  logic [7:0]       r_g, g_g, b_g, r_m, g_m, b_m;
  logic [3:0][6:0]  sym;

  assign load      = (slot_q == 3'd6);
  assign at_origin = (h_q == '0) && (v_q == '0);
  // The (0,0) symbol already belongs to the frame whose enable is being latched right now.
  assign frame_en  = at_origin ? en : en_q;
  assign de        = frame_en && (h_q < HActive) && (v_q < VActive);
  assign hs_on     = frame_en && (h_q >= HsStart) && (h_q < HsEnd);
  assign vs_on     = frame_en && (v_q >= VsStart) && (v_q < VsEnd);
  assign hs_bit    = hs_on ? HS_POL : !HS_POL;
  assign vs_bit    = vs_on ? VS_POL : !VS_POL;

  always_comb begin
    r_g = de ? red   : 8'h00;
    g_g = de ? green : 8'h00;
    b_g = de ? blue  : 8'h00;
    // JEIDA is the VESA layout fed with colours rotated so the 6 MSBs land on lanes 0-2.
    if (UseJeida) begin
      r_m = {r_g[1:0], r_g[7:2]};
      g_m = {g_g[1:0], g_g[7:2]};
      b_m = {b_g[1:0], b_g[7:2]};
    end else begin
      r_m = r_g;
      g_m = g_g;
      b_m = b_g;
    end
    sym[0] = {r_m[0], r_m[1], r_m[2], r_m[3], r_m[4], r_m[5], g_m[0]};
    sym[1] = {g_m[1], g_m[2], g_m[3], g_m[4], g_m[5], b_m[0], b_m[1]};
    sym[2] = {b_m[2], b_m[3], b_m[4], b_m[5], hs_bit, vs_bit, de};
    sym[3] = (LANES == 4) ? {r_m[6], r_m[7], g_m[6], g_m[7], b_m[6], b_m[7], 1'b0} : 7'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      slot_q <= '0;
      h_q    <= '0;
      v_q    <= '0;
      en_q   <= 1'b0;
      sh_q   <= BlankSym;
      ck_q   <= 1'b0;
      rx_q   <= '0;
    end else begin
      ck_q <= CkPattern[slot_q];
      for (int l = 0; l < 4; l++) begin
        rx_q[l] <= sh_q[l][slot_q];
      end
      if (load) begin
        slot_q <= '0;
        sh_q   <= sym;
        if (at_origin) begin
          en_q <= en;
        end
        if (h_q == HLast) begin
          h_q <= '0;
          v_q <= (v_q == VLast) ? '0 : v_q + 1'b1;
        end else begin
          h_q <= h_q + 1'b1;
        end
      end else begin
        slot_q <= slot_q + 3'd1;
      end
    end
  end

  assign pix_req     = load && de;
  assign frame_start = load && de && at_origin;
  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign tx_active   = en_q;
  assign ck1_out     = ck_q;
  assign rxin_out    = rx_q;

endmodule

// File: tb/tb_lvds_fpdlink_tx.sv
// Bench for lvds_fpdlink_tx: VESA, JEIDA and 18-bit instances on a tiny raster, compared
// cycle by cycle against a frame/pixel-position model derived from the cycle count.
module tb_lvds_fpdlink_tx;

  localparam int HA = 4, HF = 1, HSW = 1, HB = 2;
  localparam int VA = 2, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FP = HT * VT;
  localparam bit HSP = 1'b0, VSP = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] red = '0, green = '0, blue = '0;

  logic [2:0]  req_w, fs_w, act_w, ck_w;
  logic [11:0] px_w [3];
  logic [10:0] py_w [3];
  logic [3:0]  rx_w [3];

  lvds_fpdlink_tx #(
    .LANES(4), .MAP_JEIDA(1'b0), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .HS_POL(HSP), .VS_POL(VSP),
    .HW(12), .VW(11)
  ) u_vesa (
    .clk_in(clk), .rst(rst), .en(en), .red(red), .green(green), .blue(blue),
    .pix_req(req_w[0]), .pix_x(px_w[0]), .pix_y(py_w[0]), .frame_start(fs_w[0]),
    .tx_active(act_w[0]), .ck1_out(ck_w[0]), .rxin_out(rx_w[0])
  );

  lvds_fpdlink_tx #(
    .LANES(4), .MAP_JEIDA(1'b1), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .HS_POL(HSP), .VS_POL(VSP),
    .HW(12), .VW(11)
  ) u_jeida (
    .clk_in(clk), .rst(rst), .en(en), .red(red), .green(green), .blue(blue),
    .pix_req(req_w[1]), .pix_x(px_w[1]), .pix_y(py_w[1]), .frame_start(fs_w[1]),
    .tx_active(act_w[1]), .ck1_out(ck_w[1]), .rxin_out(rx_w[1])
  );

  lvds_fpdlink_tx #(
    .LANES(3), .MAP_JEIDA(1'b0), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .HS_POL(HSP), .VS_POL(VSP),
    .HW(12), .VW(11)
  ) u_18 (
    .clk_in(clk), .rst(rst), .en(en), .red(red), .green(green), .blue(blue),
    .pix_req(req_w[2]), .pix_x(px_w[2]), .pix_y(py_w[2]), .frame_start(fs_w[2]),
    .tx_active(act_w[2]), .ck1_out(ck_w[2]), .rxin_out(rx_w[2])
  );

  // Source codes: 0-7 R, 8-15 G, 16-23 B, 24 DE, 25 VS, 26 HS, 27 constant 0.
  int map_tab [3][4][7] = '{
    '{'{8, 5, 4, 3, 2, 1, 0}, '{17, 16, 13, 12, 11, 10, 9},
      '{24, 25, 26, 21, 20, 19, 18}, '{27, 23, 22, 15, 14, 7, 6}},
    '{'{10, 7, 6, 5, 4, 3, 2}, '{19, 18, 15, 14, 13, 12, 11},
      '{24, 25, 26, 23, 22, 21, 20}, '{27, 17, 16, 9, 8, 1, 0}},
    '{'{10, 7, 6, 5, 4, 3, 2}, '{19, 18, 15, 14, 13, 12, 11},
      '{24, 25, 26, 23, 22, 21, 20}, '{27, 27, 27, 27, 27, 27, 27}}
  };
  int    ck_seq [7] = '{1, 1, 0, 0, 0, 1, 1};
  string dname [3]  = '{"vesa", "jeida", "lvds18"};

  int checks = 0;
  int errors = 0;

  logic [6:0] cur_sym  [3][4];
  logic [6:0] pend_sym [3][4];
  bit         frame_on;
  bit         act_model;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] lane_word(int d, int l, logic [27:0] src);
    logic [6:0] w;
    for (int s = 0; s < 7; s++) w[s] = src[map_tab[d][l][s]];
    return w;
  endfunction

  task automatic set_pending(input logic [27:0] src);
    for (int d = 0; d < 3; d++)
      for (int l = 0; l < 4; l++) pend_sym[d][l] = lane_word(d, l, src);
  endtask

  // n = cycles since the last reset edge; n=0 is the reset-state cycle.
  task automatic model_step(input int n);
    logic [27:0] blank_src, src;
    int s, p, h, v;
    bit de, hs_on, vs_on, exp_req, exp_fs, at_org;
    blank_src = {1'b0, !HSP, !VSP, 1'b0, 24'h0};
    if (n == 0) begin
      for (int d = 0; d < 3; d++) begin
        check_eq({dname[d], "_rst_lanes"}, 32'({ck_w[d], rx_w[d]}), 32'h0);
        check_eq({dname[d], "_rst_hs"}, 32'({req_w[d], fs_w[d], act_w[d]}), 32'h0);
        check_eq({dname[d], "_rst_xy"}, 32'({px_w[d], py_w[d]}), 32'h0);
      end
      set_pending(blank_src);
      cur_sym   = pend_sym;
      frame_on  = 1'b0;
      act_model = 1'b0;
      return;
    end
    s = (n - 1) % 7;
    if (s == 0) cur_sym = pend_sym;
    for (int d = 0; d < 3; d++) begin
      check_eq({dname[d], "_lanes"}, 32'({ck_w[d], rx_w[d]}),
               32'({ck_seq[s] != 0, cur_sym[d][3][s], cur_sym[d][2][s], cur_sym[d][1][s],
                    cur_sym[d][0][s]}));
    end
    exp_req = 1'b0;
    exp_fs  = 1'b0;
    h = 0;
    v = 0;
    if (n % 7 == 6) begin
      p = (n - 6) / 7;
      h = p % HT;
      v = (p / HT) % VT;
      at_org = (p % FP == 0);
      if (at_org) frame_on = en;
      de    = frame_on && h < HA && v < VA;
      hs_on = frame_on && h >= HA + HF && h < HA + HF + HSW;
      vs_on = frame_on && v >= VA + VF && v < VA + VF + VSW;
      src = {1'b0, hs_on ? HSP : !HSP, vs_on ? VSP : !VSP, de,
             de ? blue : 8'h0, de ? green : 8'h0, de ? red : 8'h0};
      set_pending(src);
      exp_req = de;
      exp_fs  = de && at_org;
    end
    for (int d = 0; d < 3; d++) begin
      check_eq({dname[d], "_hs"}, 32'({req_w[d], fs_w[d], act_w[d]}),
               32'({exp_req, exp_fs, act_model}));
      if (exp_req) check_eq({dname[d], "_xy"}, 32'({px_w[d], py_w[d]}), 32'({12'(h), 11'(v)}));
    end
    act_model = frame_on;
  endtask

  initial begin
    int n;
    bit rst_last;
    n = 0;
    rst_last = 1'b1;
    for (int g = 0; g < 1760; g++) begin
      @(negedge clk);
      n = rst_last ? 0 : n + 1;
      // Reset at start, and again at slot 3 of active pixel (2,0) in frame 4.
      rst = (g < 3) || (g >= 1148 && g <= 1150);
      // Dropped mid frame 2 (frame 3 disabled), raised mid frame 3 (frame 4 enabled).
      en  = !(g >= 663 && g < 993);
      if (g < 3 + 7 * FP) begin
        red   = 8'hA5;
        green = 8'h3C;
        blue  = 8'h81;
      end else begin
        red   = 8'($urandom);
        green = 8'($urandom);
        blue  = 8'($urandom);
      end
      #1;
      model_step(n);
      rst_last = rst;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
